// File: rtl/lif_neuron_array.sv
// Purpose: time-multiplexed bank of leaky integrate-and-fire neurons sharing one datapath.
// Latency: 1 cycle from accept to out_*; one update accepted per cycle.
// Backpressure: in_ready drops with clear and during the N-cycle clear sweep; no output stall.
module lif_neuron_array #(
  parameter int N_NEURONS    = 4,
  parameter int U_WIDTH      = 8,
  parameter int REFRAC_WIDTH = 3,
  parameter int RESET_MODE   = 0,
  parameter int IDX_W        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic [U_WIDTH-1:0]      in_sum_wx,
  input  logic [U_WIDTH-1:0]      threshold,
  input  logic [3:0]              leak_shift,
  input  logic [REFRAC_WIDTH-1:0] refrac_period,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_spike,
  output logic [U_WIDTH-1:0]      out_u
);

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_clr_idx;
  logic signed [U_WIDTH-1:0]       r_u   [N_NEURONS];
  logic [REFRAC_WIDTH-1:0]         r_ref [N_NEURONS];
  logic                            r_out_vld;
  logic [IDX_W-1:0]                r_out_idx;
  logic                            r_out_spk;
  logic [U_WIDTH-1:0]              r_out_u;

  logic                            w_idx_ok;
  logic signed [U_WIDTH-1:0]       w_u;
  logic [REFRAC_WIDTH-1:0]         w_r;
  logic                            w_refr;
  logic signed [U_WIDTH-1:0]       w_shifted;
  logic signed [U_WIDTH-1:0]       w_leak;
  logic signed [U_WIDTH:0]         w_sum;
  logic signed [U_WIDTH-1:0]       w_sat;
  logic signed [U_WIDTH-1:0]       w_acc;
  logic [U_WIDTH-1:0]              w_thr;
  logic signed [U_WIDTH:0]         w_acc_x;
  logic signed [U_WIDTH:0]         w_thr_x;
  logic                            w_spike;
  logic [U_WIDTH-1:0]              w_diff;
  logic [U_WIDTH-1:0]              w_u_new;
  logic [REFRAC_WIDTH-1:0]         w_r_new;

  // Updates are only taken in RUN, and never in the cycle clear is requested.
  assign in_ready  = (r_state == ST_RUN) && !clear;
  assign out_valid = r_out_vld;
  assign out_idx   = r_out_idx;
  assign out_spike = r_out_spk;
  assign out_u     = r_out_u;

  // Select the addressed neuron's state; out-of-range indices read as zero and are never written.
  always_comb begin
    w_idx_ok = 1'b0;
    w_u      = '0;
    w_r      = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (32'(in_idx) == k) begin
        w_idx_ok = 1'b1;
        w_u      = r_u[k];
        w_r      = r_ref[k];
      end
    end
  end

  // Shared leak / saturating integrate / threshold / reset datapath.
  always_comb begin
    w_refr    = (w_r != '0);
    w_shifted = w_u >>> leak_shift;
    // u - (u >>> k) always fits in U_WIDTH for k >= 1, so no widening is needed here.
    w_leak    = (leak_shift == 4'd0) ? w_u : (w_u - w_shifted);
    w_sum     = {w_leak[U_WIDTH-1], w_leak} + {in_sum_wx[U_WIDTH-1], in_sum_wx};
    if (w_sum[U_WIDTH] != w_sum[U_WIDTH-1])
      w_sat = w_sum[U_WIDTH] ? {1'b1, {(U_WIDTH-1){1'b0}}} : {1'b0, {(U_WIDTH-1){1'b1}}};
    else
      w_sat = w_sum[U_WIDTH-1:0];
    w_acc   = w_refr ? w_leak : w_sat;
    w_thr   = (threshold == '0) ? {{(U_WIDTH-1){1'b0}}, 1'b1} : threshold;
    // Threshold is unsigned, so compare with one extra bit to keep it positive.
    w_acc_x = {w_acc[U_WIDTH-1], w_acc};
    w_thr_x = {1'b0, w_thr};
    w_spike = !w_refr && (w_acc_x >= w_thr_x);
    // On a spike 1 <= thr <= acc, so the difference is non-negative and fits U_WIDTH bits.
    w_diff  = w_acc - w_thr;
    if (w_spike)
      w_u_new = (RESET_MODE != 0) ? '0 : w_diff;
    else
      w_u_new = w_acc;
    if (w_spike)
      w_r_new = refrac_period;
    else if (w_refr)
      w_r_new = w_r - 1'b1;
    else
      w_r_new = w_r;
  end

  // Run/clear controller, neuron state write-back and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_clr_idx <= '0;
      r_out_vld <= 1'b0;
      r_out_idx <= '0;
      r_out_spk <= 1'b0;
      r_out_u   <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        r_u[k]   <= '0;
        r_ref[k] <= '0;
      end
    end else begin
      r_out_vld <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (clear) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
          end else if (in_valid && w_idx_ok) begin
            for (int k = 0; k < N_NEURONS; k++) begin
              if (32'(in_idx) == k) begin
                r_u[k]   <= w_u_new;
                r_ref[k] <= w_r_new;
              end
            end
            r_out_vld <= 1'b1;
            r_out_idx <= in_idx;
            r_out_spk <= w_spike;
            r_out_u   <= w_u_new;
          end
        end
        ST_CLEAR: begin
          for (int k = 0; k < N_NEURONS; k++) begin
            if (32'(r_clr_idx) == k) begin
              r_u[k]   <= '0;
              r_ref[k] <= '0;
            end
          end
          if (32'(r_clr_idx) == N_NEURONS - 1)
            r_state <= ST_RUN;
          else
            r_clr_idx <= r_clr_idx + IDX_W'(1);
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Purpose: randomized and directed check of lif_neuron_array against a behavioural neuron model.
// Latency: each accepted update is checked one cycle later, sampled 1 time unit after the edge.
// Backpressure: clear sweeps are timed by watching in_ready with a bounded wait.
module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int UW = 8;
  localparam int RW = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_idx = '0;
  logic [UW-1:0] in_sum_wx = '0;
  logic [UW-1:0] threshold = 8'd64;
  logic [3:0]    leak_shift = 4'd0;
  logic [RW-1:0] refrac_period = '0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          out_spike;
  logic [UW-1:0] out_u;

  lif_neuron_array #(
    .N_NEURONS(N), .U_WIDTH(UW), .REFRAC_WIDTH(RW), .RESET_MODE(0), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_sum_wx(in_sum_wx), .threshold(threshold),
    .leak_shift(leak_shift), .refrac_period(refrac_period), .clear(clear),
    .out_valid(out_valid), .out_idx(out_idx), .out_spike(out_spike), .out_u(out_u)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mu [N];
  int mr [N];
  int last_u = 0;
  int last_idx = 0;
  int last_spk = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int sval(input logic [UW-1:0] v);
    return int'($signed(v));
  endfunction

  // Neuron behaviour from the rules: leak, integrate with clamping, fire, reset by subtraction.
  function automatic void model(input int idx, input int sum, output int un, output int spk);
    int u, lk, acc, th;
    u   = mu[idx];
    lk  = (leak_shift == 0) ? u : u - (u >>> leak_shift);
    th  = (threshold == 0) ? 1 : int'(threshold);
    spk = 0;
    if (mr[idx] != 0) begin
      acc = lk;
      mr[idx] = mr[idx] - 1;
    end else begin
      acc = lk + sum;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      spk = (acc >= th) ? 1 : 0;
    end
    if (spk != 0) begin
      un = acc - th;
      mr[idx] = int'(refrac_period);
    end else begin
      un = acc;
    end
    mu[idx] = un;
  endfunction

  task automatic zero_model();
    for (int k = 0; k < N; k++) begin
      mu[k] = 0;
      mr[k] = 0;
    end
  endtask

  // One update; exp_u other than 9999 is an additional hand-computed expectation.
  task automatic do_upd(input int idx, input int sum, input int exp_u = 9999);
    int un, spk;
    in_valid  = 1'b1;
    in_idx    = idx[IW-1:0];
    in_sum_wx = sum[UW-1:0];
    #1;
    chk("ready", int'(in_ready), 1);
    if (idx < N) model(idx, sum, un, spk);
    @(posedge clk);
    #1;
    if (idx < N) begin
      chk("out_valid", int'(out_valid), 1);
      chk("out_idx", int'(out_idx), idx);
      chk("out_u", sval(out_u), un);
      chk("out_spike", int'(out_spike), spk);
      last_u = un; last_idx = idx; last_spk = spk;
      if (exp_u != 9999) chk("out_u_hand", sval(out_u), exp_u);
    end else begin
      chk("bad_idx_no_valid", int'(out_valid), 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", int'(out_valid), 0);
    chk("hold_u", sval(out_u), last_u);
    chk("hold_idx", int'(out_idx), last_idx);
    chk("hold_spike", int'(out_spike), last_spk);
  endtask

  // Clear pulse with an update held; a second clear inside the sweep must be ignored.
  task automatic do_clear();
    int cnt;
    in_valid  = 1'b1;
    in_idx    = IW'($urandom_range(0, N - 1));
    in_sum_wx = UW'($urandom_range(0, 255));
    clear     = 1'b1;
    #1;
    chk("clr_ready_drop", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    cnt = 0;
    while (in_ready === 1'b0 && cnt < 10) begin
      chk("clr_no_valid", int'(out_valid), 0);
      chk("clr_hold_u", sval(out_u), last_u);
      clear = (cnt == 1);
      @(posedge clk);
      #1;
      cnt++;
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_len", cnt, N);
    zero_model();
  endtask

  task automatic do_reset();
    in_valid  = 1'b1;
    in_idx    = '0;
    in_sum_wx = 8'd50;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_u", sval(out_u), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_spike", int'(out_spike), 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    zero_model();
    last_u = 0; last_idx = 0; last_spk = 0;
    #1;
    chk("rst_ready", int'(in_ready), 1);
  endtask

  initial begin
    int r, s;
    zero_model();
    do_reset();

    // Integration, then refractory hold after the firing update.
    threshold = 8'd64; leak_shift = 4'd0; refrac_period = 3'd0;
    do_upd(0, 20, 20);
    do_upd(0, 20, 40);
    refrac_period = 3'd2;
    do_upd(0, 30, 6);
    chk("int_spike", int'(out_spike), 1);
    do_upd(0, 50, 6);
    do_upd(0, 50, 6);
    do_upd(0, 50, 56);
    chk("refr_end_spike", int'(out_spike), 0);
    refrac_period = 3'd0;

    // Leak.
    do_upd(1, 40, 40);
    leak_shift = 4'd2;
    do_upd(1, 0, 30);
    do_upd(1, 0, 23);
    leak_shift = 4'd0;

    // Saturation in both directions.
    threshold = 8'd127;
    do_upd(2, 100, 100);
    do_upd(3, -100, -100);
    threshold = 8'd64;
    do_upd(2, 100, 63);
    chk("sat_hi_spike", int'(out_spike), 1);
    do_upd(3, -100, -128);
    chk("sat_lo_spike", int'(out_spike), 0);

    // Out-of-range index, then outputs must hold.
    do_upd(5, 77);
    do_idle();

    // Clear mid-stream, then each neuron starts from zero.
    do_upd(1, 10);
    do_upd(2, 5);
    do_clear();
    for (int i = 0; i < N; i++) begin
      s = int'($urandom_range(0, 120)) - 60;
      do_upd(i, s, s);
    end

    // Reset mid-stream, then each neuron starts from zero.
    do_upd(3, 33);
    do_reset();
    for (int i = 0; i < N; i++) begin
      s = int'($urandom_range(0, 120)) - 60;
      do_upd(i, s, s);
    end

    // Randomized traffic with changing controls.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_clear();
      end else if (r < 5) begin
        do_reset();
      end else if (r < 15) begin
        do_idle();
      end else begin
        if ($urandom_range(0, 3) == 0) threshold = UW'($urandom_range(0, 140));
        if ($urandom_range(0, 3) == 0) leak_shift = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) refrac_period = RW'($urandom_range(0, 7));
        do_upd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Time-multiplexed bank of N leaky integrate-and-fire neurons that share one integrate/leak/threshold datapath. Each membrane potential and refractory counter is held in internal state. Each accepted input updates one neuron per cycle, applying leak, saturating integration, threshold compare and reset, and reports the result one cycle later. The block sits between the synaptic weighted-sum stage and the spike-output/encoder logic.

Parameters:
N_NEURONS, 4, number of neurons held; index width IDX_W = max(1, clog2(N_NEURONS))
U_WIDTH, 8, signed two's-complement width of membrane potential and sum_wx
REFRAC_WIDTH, 3, width of per-neuron refractory counter
RESET_MODE, 0, 0 = reset by subtraction (u - threshold), 1 = reset to zero

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  update request valid
in_ready  out  1  block can accept an update this cycle
in_idx  in  IDX_W  neuron to update; values >= N_NEURONS are accepted and ignored (no out_valid)
in_sum_wx  in  U_WIDTH  signed weighted input sum for this step
threshold  in  U_WIDTH  unsigned firing threshold; 0 is treated as 1
leak_shift  in  4  leak = u >>> leak_shift; 0 = no leak
refrac_period  in  REFRAC_WIDTH  updates ignored after a spike
clear  in  1  one-cycle request to zero all neurons
out_valid  out  1  result valid, one-cycle pulse
out_idx  out  IDX_W  neuron that was updated
out_spike  out  1  neuron fired on this update
out_u  out  U_WIDTH  new membrane potential, signed

Behaviour:
- Reset (rst_n=0 at clk edge): all membranes, refractory counters and outputs are 0; state = RUN; in_ready = 1 in the cycle after reset release.
- States: RUN, CLEAR. In RUN, in_ready = 1.
  - clear=1 in RUN moves the block to CLEAR. An update presented in that same cycle is not accepted (in_ready drops combinationally with clear).
  - CLEAR sweeps indices 0..N_NEURONS-1, one per cycle, zeroing membrane and refractory state. in_ready = 0 for these N_NEURONS cycles, then the block returns to RUN.
  - clear is ignored while in CLEAR. Reset during CLEAR aborts the sweep and applies normal reset.
- Accept occurs when in_valid & in_ready at a clk edge. Inputs are sampled at that edge. Results appear on out_* in the next cycle with out_valid=1. Latency is 1 cycle, throughput is 1 update per cycle. There is no output backpressure.
- Datapath for neuron i (u = stored potential, r = refractory count):
  - leaked = (leak_shift==0) ? u : u - (u >>> leak_shift), using arithmetic shift. Shifts >= U_WIDTH give a >>> result of 0 or -1.
  - If r != 0: acc = leaked, in_sum_wx is ignored, r decrements by 1.
  - Otherwise acc = sat(leaked + in_sum_wx), clamped to [-2^(U_WIDTH-1), 2^(U_WIDTH-1)-1].
  - spike = (acc >= threshold), using a U_WIDTH+1-bit signed compare. Spike is forced to 0 while refractory.
  - On spike: u_new = RESET_MODE ? 0 : acc - threshold, and r loads refrac_period.
  - Without spike: u_new = acc.
  - out_u = u_new. out_spike = spike.
- Write-through: state updates at the accept edge. A back-to-back update of the same index reads the new value, with no stall.
- out_valid is 0 on any cycle without a prior-cycle valid accept, and 0 during CLEAR. out_idx/out_u/out_spike hold their last values when out_valid=0.
- Control inputs (threshold, leak_shift, refrac_period) may change on any cycle and take effect on the next accept.

Test Plan:
Common config: N_NEURONS=4, U_WIDTH=8, threshold=64, RESET_MODE=0.
- Integration: leak_shift=0, refrac=0. idx0 gets sum 20, 20, 30 on consecutive cycles. Required out_u = 20, 40, 6, with out_spike only on the third update. Each result appears one cycle after accept.
- Leak: idx1 preloaded to 40. Apply leak_shift=2 and sum 0. Required out_u = 30, no spike. Repeat the same update: required out_u = 23.
- Saturation: idx2 at 100 with sum 100 → out_u=63 (127-64), spike=1. idx3 at -100 with sum -100 → out_u = -128, spike=0.
- Refractory: refrac_period=2, leak_shift=0. idx0 fires (u=6) and then receives sum 50 three times. Required out_u = 6, 6, 56, with no spike on any of these updates.
- Clear mid-stream: with in_valid held, pulse clear. Required: in_ready=0 for exactly 4 cycles and no out_valid during them. Every later first update returns out_u = sum_wx.
- Reset and invalid index: rst_n low mid-stream zeroes outputs and state. in_idx=5 (N=4 with IDX_W=3) is accepted with no out_valid and no state change.
